// File: rtl/pipe_sequencer_if.sv
// Pipeline-control bundle between the hazard/debug sources and the sequencer.
// Handshake: none; all fields are single-cycle levels or pulses sampled on clk.
interface pipe_sequencer_if #(
    parameter int REG_ADDR_WID = 3
);
    logic [REG_ADDR_WID-1:0] id_rs1;
    logic [REG_ADDR_WID-1:0] id_rs2;
    logic                    id_use_rs1;
    logic                    id_use_rs2;
    logic                    ex_is_load;
    logic [REG_ADDR_WID-1:0] ex_rd;
    logic                    branch_taken;
    logic                    halt_req;
    logic                    run_req;
    logic                    step_req;
    logic                    if_en;
    logic                    id_en;
    logic                    ex_en;
    logic                    ex_bubble;
    logic                    flush_if_id;
    logic                    halted;
    logic [15:0]             stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_is_load, ex_rd,
        output branch_taken, halt_req, run_req, step_req,
        input  if_en, id_en, ex_en, ex_bubble, flush_if_id, halted, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_is_load, ex_rd,
        input  branch_taken, halt_req, run_req, step_req,
        output if_en, id_en, ex_en, ex_bubble, flush_if_id, halted, stall_cnt
    );
endinterface

// File: rtl/pipe_sequencer.sv
// Central pipeline control: boot freeze, load-use stalls, branch flushes and
// debug halt/run/single-step. Control outputs are Mealy on hazard inputs.
module pipe_sequencer #(
    parameter int REG_ADDR_WID = 3,
    parameter int BOOT_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int LOAD_LAT     = 1
) (
    input  logic                clk,
    input  logic                rst,
    pipe_sequencer_if.slave     bus,
    output logic [2:0]          o_state
);

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_RUN    = 3'd1,
        S_LSTALL = 3'd2,
        S_BFLUSH = 3'd3,
        S_HALT   = 3'd4,
        S_STEP   = 3'd5
    } state_t;

    localparam logic [3:0] CNT_BOOT  = 4'(BOOT_CYCLES - 1);
    localparam logic [3:0] CNT_FLUSH = 4'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);
    localparam logic [3:0] CNT_LOAD  = 4'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic                    r_ret_halt;
    logic [15:0]             r_stall_cnt;

    state_t                  w_state_nxt;
    logic [3:0]              w_cnt_nxt;
    logic                    w_ret_halt_nxt;

    logic [REG_ADDR_WID-1:0] w_rs1;
    logic [REG_ADDR_WID-1:0] w_rs2;
    logic [REG_ADDR_WID-1:0] w_rd;
    logic                    w_lu;

    logic                    w_if_en;
    logic                    w_id_en;
    logic                    w_ex_en;
    logic                    w_ex_bubble;
    logic                    w_flush;
    logic                    w_halted;
    logic                    w_stall_inc;

    assign w_rs1 = bus.id_rs1;
    assign w_rs2 = bus.id_rs2;
    assign w_rd  = bus.ex_rd;
    assign w_lu  = bus.ex_is_load &
                   ((bus.id_use_rs1 && (w_rs1 == w_rd)) ||
                    (bus.id_use_rs2 && (w_rs2 == w_rd)));

    // State register; reset drops straight into BOOT so outputs go quiet at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_BOOT;
            r_cnt       <= CNT_BOOT;
            r_ret_halt  <= 1'b0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ret_halt <= w_ret_halt_nxt;
            if (w_stall_inc && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ret_halt_nxt = r_ret_halt;
        case (r_state)
            S_BOOT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = bus.halt_req ? S_HALT : S_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RUN, S_STEP: begin
                // ret_halt only survives when a step launches a multi-cycle hazard.
                w_ret_halt_nxt = 1'b0;
                if (bus.branch_taken) begin
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt    = S_BFLUSH;
                        w_cnt_nxt      = CNT_FLUSH;
                        w_ret_halt_nxt = (r_state == S_STEP);
                    end else begin
                        w_state_nxt = (r_state == S_STEP) ? S_HALT : S_RUN;
                    end
                end else if (w_lu) begin
                    if (LOAD_LAT > 1) begin
                        w_state_nxt    = S_LSTALL;
                        w_cnt_nxt      = CNT_LOAD;
                        w_ret_halt_nxt = (r_state == S_STEP);
                    end else begin
                        w_state_nxt = (r_state == S_STEP) ? S_HALT : S_RUN;
                    end
                end else if (r_state == S_STEP) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = bus.halt_req ? S_HALT : S_RUN;
                end
            end
            S_LSTALL, S_BFLUSH: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt    = r_ret_halt ? S_HALT : S_RUN;
                    w_ret_halt_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_HALT: begin
                w_ret_halt_nxt = 1'b0;
                if (bus.run_req) begin
                    w_state_nxt = S_RUN;
                end else if (bus.step_req) begin
                    w_state_nxt = S_STEP;
                end
            end
            default: begin
                w_state_nxt    = S_BOOT;
                w_cnt_nxt      = CNT_BOOT;
                w_ret_halt_nxt = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_if_en     = 1'b0;
        w_id_en     = 1'b0;
        w_ex_en     = 1'b0;
        w_ex_bubble = 1'b0;
        w_flush     = 1'b0;
        w_halted    = 1'b0;
        w_stall_inc = 1'b0;
        case (r_state)
            S_RUN, S_STEP: begin
                w_if_en = 1'b1;
                w_id_en = 1'b1;
                w_ex_en = 1'b1;
                // A taken branch squashes the dependent instruction, so no stall.
                if (bus.branch_taken) begin
                    w_flush = 1'b1;
                end else if (w_lu) begin
                    w_if_en     = 1'b0;
                    w_id_en     = 1'b0;
                    w_ex_bubble = 1'b1;
                    w_stall_inc = 1'b1;
                end
            end
            S_LSTALL: begin
                w_ex_en     = 1'b1;
                w_ex_bubble = 1'b1;
                w_stall_inc = 1'b1;
            end
            S_BFLUSH: begin
                w_if_en = 1'b1;
                w_id_en = 1'b1;
                w_ex_en = 1'b1;
                w_flush = 1'b1;
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_if_en = 1'b0;
            end
        endcase
    end

    assign bus.if_en       = w_if_en;
    assign bus.id_en       = w_id_en;
    assign bus.ex_en       = w_ex_en;
    assign bus.ex_bubble   = w_ex_bubble;
    assign bus.flush_if_id = w_flush;
    assign bus.halted      = w_halted;
    assign bus.stall_cnt   = r_stall_cnt;
    assign o_state         = r_state;

endmodule

// File: doc/pipe_sequencer.md
Name: pipe_sequencer

Overview:
- Central pipeline control for the 16-bit, 8-bit-PC processor.
- Generates the IF-stage fetch enable (drives IF `enable1`), the ID/EX enables, a bubble into EX and the IF/ID flush.
- Sequences boot-up after reset, load-use stalls, taken-branch flushes, and debug halt/run/single-step.
- Sits beside the pipeline; hazard inputs come from ID/EX registers, and debug requests come from the test interface.

Parameters:
- REG_ADDR_WID, 3: width of register specifiers compared for hazards.
- BOOT_CYCLES, 2: cycles all stages stay frozen after reset release (imem output settle); legal range 1-15.
- FLUSH_CYCLES, 2: cycles flush_if_id stays high after a taken branch, including the branch cycle; legal range 1-7.
- LOAD_LAT, 1: stall cycles per load-use hazard, including the detection cycle; legal range 1-7.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs1  in  REG_ADDR_WID  source reg 1 of instruction in ID
- id_rs2  in  REG_ADDR_WID  source reg 2 of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_is_load  in  1  instruction in EX is OP_LD
- ex_rd  in  REG_ADDR_WID  destination reg of instruction in EX
- branch_taken  in  1  EX resolved a taken OP_BZ this cycle
- halt_req  in  1  level; request freeze
- run_req  in  1  pulse; leave HALT
- step_req  in  1  pulse; execute one cycle from HALT
- if_en  out  1  to IF enable1
- id_en  out  1  IF/ID register load
- ex_en  out  1  EX/MEM/WB advance
- ex_bubble  out  1  load NOP into ID/EX
- flush_if_id  out  1  replace IF/ID contents with NOP
- halted  out  1  state==HALT
- stall_cnt  out  16  count of hazard-stall cycles

Behaviour:
- States: BOOT, RUN, LSTALL, BFLUSH, HALT, STEP. A 4-bit down-counter cnt and a 1-bit ret_halt flag are used.
- Reset (async): state=BOOT, cnt=BOOT_CYCLES-1, ret_halt=0, stall_cnt=0.
- Outputs during and after reset in BOOT: if_en=id_en=ex_en=ex_bubble=flush_if_id=halted=0.

BOOT:
- All outputs 0; cnt decrements each cycle.
- At cnt==0: next state = HALT if halt_req, else RUN.

RUN/STEP evaluation (outputs are Mealy on inputs):
- Defaults: if_en=id_en=ex_en=1, others 0.
- lu = ex_is_load & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority 1, branch_taken: if_en=1 (PC takes the offset), flush_if_id=1, lu ignored.
  - If FLUSH_CYCLES>1: go to BFLUSH with cnt=FLUSH_CYCLES-2.
- Priority 2, lu: if_en=id_en=0, ex_bubble=1, stall_cnt increments.
  - If LOAD_LAT>1: go to LSTALL with cnt=LOAD_LAT-2.
- No hazard in RUN: go to HALT if halt_req, else stay in RUN.
- Halt timing: halt_req is sampled only in a RUN cycle with no hazard, so an in-progress stall or flush always completes first.
- STEP: ret_halt=1. If no multi-cycle hazard started, next state = HALT.

LSTALL:
- if_en=id_en=0, ex_en=1, ex_bubble=1; stall_cnt increments.
- At cnt==0: next state = HALT if ret_halt, else RUN; clear ret_halt.

BFLUSH:
- if_en=id_en=ex_en=1, flush_if_id=1.
- branch_taken in BFLUSH is ignored (the branch is a squashed instruction).
- At cnt==0: next state = HALT if ret_halt, else RUN; clear ret_halt.

HALT:
- All enables 0, ex_bubble=0, flush_if_id=0, halted=1.
- run_req: go to RUN (takes priority over step_req).
- step_req (without run_req): go to STEP.
- halt_req level is ignored in HALT.

stall_cnt:
- Saturates at 16'hFFFF; does not count in BOOT, HALT or BFLUSH.

Reset mid-operation: async return to BOOT, with all outputs 0 immediately.

Test Plan:
1. Boot: rst high 3 cycles then low, no hazards -> all enables 0 for 2 cycles after release; if_en=1 on 3rd cycle; PC reaches 1 one cycle later.
2. Load-use hazard: ex_is_load=1, ex_rd=3, id_use_rs2=1, id_rs2=3 for one cycle -> that cycle if_en=id_en=0, ex_bubble=1; stall_cnt 0->1; next cycle (hazard inputs cleared) if_en=1.
   - Repeat with id_use_rs2=0 -> no stall.
3. Branch plus hazard: branch_taken=1 and a load-use match in the same cycle -> if_en=1, flush_if_id=1, ex_bubble=0; flush_if_id=1 again next cycle (BFLUSH); stall_cnt unchanged; then RUN.
4. Halt: halt_req raised during an LSTALL with LOAD_LAT=3 -> stall completes (3 cycles), then halted=1 with all enables 0.
   - run_req pulse -> RUN next cycle; halted=0.
5. Step: in HALT, step_req pulse -> exactly one cycle with if_en=id_en=ex_en=1, then halted=1.
   - Step with branch_taken=1 -> 2 flush cycles, then HALT.
6. Async reset mid-BFLUSH: rst asserted between edges -> outputs 0 immediately; stall_cnt=0; BOOT sequence restarts.
   - Saturation: force 70000 stall cycles -> stall_cnt holds 16'hFFFF.
